// File: rtl/forward_hazard_ctrl.sv
// EX-stage forwarding select generator with load-use stall, branch flush and
// saturating stall/flush event counters.
module forward_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold_ext,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                      use_rs1_ID,
    input  logic                      use_rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_EX,
    input  logic                      regwrite_EX,
    input  logic                      memread_EX,
    input  logic [REG_ADDR_WIDTH-1:0] rd_MEM,
    input  logic                      regwrite_MEM,
    input  logic                      pc_src_EX,
    output logic [2:0]                forward_detect_EX_rs1,
    output logic [2:0]                forward_detect_EX_rs2,
    output logic                      stall_IF,
    output logic                      stall_ID,
    output logic                      flush_ID,
    output logic                      flush_EX,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [2:0] FWD_MEM  = 3'b001;
    localparam logic [2:0] FWD_WB   = 3'b010;
    localparam logic [2:0] FWD_NONE = 3'b100;

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t                 state_q;
    logic [2:0]             fwd_rs1_q, fwd_rs1_d;
    logic [2:0]             fwd_rs2_q, fwd_rs2_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, flush_cnt_q;

    logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
    logic lu, stall_w, flush_w;

    assign hit_ex_rs1  = use_rs1_ID & regwrite_EX  & (rd_EX  == rs1_ID) & (rs1_ID != '0);
    assign hit_ex_rs2  = use_rs2_ID & regwrite_EX  & (rd_EX  == rs2_ID) & (rs2_ID != '0);
    assign hit_mem_rs1 = use_rs1_ID & regwrite_MEM & (rd_MEM == rs1_ID) & (rs1_ID != '0);
    assign hit_mem_rs2 = use_rs2_ID & regwrite_MEM & (rd_MEM == rs2_ID) & (rs2_ID != '0);

    // The replay cycle after a load-use stall sees the load in MEM, so no new lu is raised there.
    assign lu = memread_EX & (hit_ex_rs1 | hit_ex_rs2) & (state_q == RUN);

    always_comb begin
        stall_w = 1'b0;
        flush_w = 1'b0;
        if (!hold_ext) begin
            flush_w = pc_src_EX;
            stall_w = lu & ~pc_src_EX;
        end
    end

    assign stall_IF = stall_w;
    assign stall_ID = stall_w;
    assign flush_ID = flush_w;
    assign flush_EX = flush_w | stall_w;

    always_comb begin
        fwd_rs1_d = FWD_NONE;
        fwd_rs2_d = FWD_NONE;
        if (hit_ex_rs1)       fwd_rs1_d = FWD_MEM;
        else if (hit_mem_rs1) fwd_rs1_d = FWD_WB;
        if (hit_ex_rs2)       fwd_rs2_d = FWD_MEM;
        else if (hit_mem_rs2) fwd_rs2_d = FWD_WB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fwd_rs1_q   <= FWD_NONE;
            fwd_rs2_q   <= FWD_NONE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hold_ext) begin
            state_q <= stall_w ? LU_STALL : RUN;
            if (flush_EX) begin
                fwd_rs1_q <= FWD_NONE;
                fwd_rs2_q <= FWD_NONE;
            end else begin
                fwd_rs1_q <= fwd_rs1_d;
                fwd_rs2_q <= fwd_rs2_d;
            end
            if (stall_w && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_w && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign forward_detect_EX_rs1 = fwd_rs1_q;
    assign forward_detect_EX_rs2 = fwd_rs2_q;
    assign stall_cnt             = stall_cnt_q;
    assign flush_cnt             = flush_cnt_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboard bench for forward_hazard_ctrl: stimulus pushes expected outputs,
// a monitor pops and compares them every cycle.
module tb_forward_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold_ext;
    logic [4:0]    rs1_ID, rs2_ID, rd_EX, rd_MEM;
    logic          use_rs1_ID, use_rs2_ID, regwrite_EX, memread_EX, regwrite_MEM, pc_src_EX;
    logic [2:0]    fwd1, fwd2;
    logic          stall_IF, stall_ID, flush_ID, flush_EX;
    logic [CW-1:0] stall_cnt, flush_cnt;

    forward_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hold_ext(hold_ext),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .rd_EX(rd_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM), .pc_src_EX(pc_src_EX),
        .forward_detect_EX_rs1(fwd1), .forward_detect_EX_rs2(fwd2),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID), .flush_EX(flush_EX),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // expected record: {stall_IF, stall_ID, flush_ID, flush_EX, fwd1, fwd2, stall_cnt, flush_cnt}
    logic [17:0] exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    int m_f1 = 4, m_f2 = 4, m_sc = 0, m_fc = 0;
    bit m_replay = 0;

    function automatic int src_sel(bit use_s, int s, bit rwex, int rdex, bit rwmem, int rdmem);
        if (use_s && s != 0 && rwex && rdex == s) return 1;
        if (use_s && s != 0 && rwmem && rdmem == s) return 2;
        return 4;
    endfunction

    task automatic cyc(input bit rst, input bit hold, input int r1, input bit u1,
                       input int r2, input bit u2, input int rdex, input bit rwex,
                       input bit mr, input int rdmem, input bit rwmem, input bit br);
        int  s1, s2;
        bit  lu, stall, fid, fex;
        @(negedge clk);
        rst_n = rst; hold_ext = hold;
        rs1_ID = 5'(r1); use_rs1_ID = u1; rs2_ID = 5'(r2); use_rs2_ID = u2;
        rd_EX = 5'(rdex); regwrite_EX = rwex; memread_EX = mr;
        rd_MEM = 5'(rdmem); regwrite_MEM = rwmem; pc_src_EX = br;
        if (!rst) begin
            m_f1 = 4; m_f2 = 4; m_sc = 0; m_fc = 0; m_replay = 0;
        end
        s1 = src_sel(u1, r1, rwex, rdex, rwmem, rdmem);
        s2 = src_sel(u2, r2, rwex, rdex, rwmem, rdmem);
        lu = mr && (s1 == 1 || s2 == 1) && !m_replay;
        stall = !hold && lu && !br;
        fid   = !hold && br;
        fex   = fid || stall;
        exp_q.push_back({stall, stall, fid, fex, 3'(m_f1), 3'(m_f2), 4'(m_sc), 4'(m_fc)});
        if (rst && !hold) begin
            m_f1 = fex ? 4 : s1;
            m_f2 = fex ? 4 : s2;
            if (stall && m_sc < CMAX) m_sc++;
            if (fid && m_fc < CMAX) m_fc++;
            m_replay = stall;
        end
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        logic [17:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {stall_IF, stall_ID, flush_ID, flush_EX, fwd1, fwd2, stall_cnt, flush_cnt};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_outputs t=%0t got st=%b%b fl=%b%b f1=%b f2=%b sc=%0d fc=%0d want st=%b%b fl=%b%b f1=%b f2=%b sc=%0d fc=%0d",
                             $time, act_v[17], act_v[16], act_v[15], act_v[14], act_v[13:11], act_v[10:8], act_v[7:4], act_v[3:0],
                             exp_v[17], exp_v[16], exp_v[15], exp_v[14], exp_v[13:11], exp_v[10:8], exp_v[7:4], exp_v[3:0]);
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; hold_ext = 1'b0;
        rs1_ID = '0; rs2_ID = '0; use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
        rd_EX = '0; regwrite_EX = 1'b0; memread_EX = 1'b0;
        rd_MEM = '0; regwrite_MEM = 1'b0; pc_src_EX = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // 1: EX producer -> MEM forward
        cyc(1, 0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0); idle();
        // 2: EX and MEM both write x5, EX wins
        cyc(1, 0, 3, 1, 5, 1, 5, 1, 0, 5, 1, 0); idle();
        // 3: load-use stall then WB forward on replay
        cyc(1, 0, 6, 1, 0, 0, 6, 1, 1, 0, 0, 0);
        cyc(1, 0, 6, 1, 0, 0, 0, 0, 0, 6, 1, 0); idle();
        // 4: load-use with simultaneous branch
        cyc(1, 0, 7, 1, 0, 0, 7, 1, 1, 0, 0, 1); idle();
        // 5: x0 never forwards; hold freezes state
        cyc(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 9, 1, 0, 0, 9, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 9, 1, 4, 1, 9, 1, 1, 4, 1, 1);
        idle();
        // 6: reset during the replay cycle
        cyc(1, 0, 6, 1, 6, 1, 6, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // counter saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            cyc(1, 0, 2, 1, 0, 0, 2, 1, 1, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
        end
        idle();
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
